// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: multi-cycle multiply/divide sequencer and owner of the
// architectural HI/LO pair.
//  - MULTU/MULT use a shift-add multiplier, DIVU/DIV a restoring divider;
//    each takes WIDTH iterations, one per clock.
//  - MTHI/MTLO write HI/LO in the accepting cycle.
//  - hi_out/lo_out only change on MT writes or on final commit, so the block
//    never exposes a partial result.
// Optional feature macro: SIGNED_MULDIV_EN (enables op_codes 5 MULT / 6 DIV).
//
// Handshake: an op is taken at a rising edge when op_valid=1, busy=0 and
// flush=0. While busy=1 the EX stage must hold its op (stall tells it so);
// nothing is queued inside this block.
module muldiv_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_req,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [1:0]       dbg_state
);

`ifdef SIGNED_MULDIV_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH:0]   acc_q;      // multiplier accumulator / divider partial remainder
  logic [WIDTH-1:0] q_q;        // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] b_q;        // multiplicand / divisor magnitude
  logic [CW-1:0]    cnt_q;
  logic             neg_lo_q;   // negate product (mul) or quotient (div) at commit
  logic             neg_hi_q;   // negate remainder at commit (div only)

  // Op decode and acceptance
  logic op_mul, op_div, op_signed, op_mthi, op_mtlo, accept, last_iter;
  assign op_mul    = (op_code == 3'd1) | (SIGNED_EN & (op_code == 3'd5));
  assign op_div    = (op_code == 3'd2) | (SIGNED_EN & (op_code == 3'd6));
  assign op_signed = SIGNED_EN & ((op_code == 3'd5) | (op_code == 3'd6));
  assign op_mthi   = (op_code == 3'd3);
  assign op_mtlo   = (op_code == 3'd4);
  assign accept    = op_valid & ~busy_q & ~flush;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Operand magnitudes and sign of each source
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sign_a = op_signed & src_a[WIDTH-1];
  assign sign_b = op_signed & src_b[WIDTH-1];
  assign mag_a  = sign_a ? -src_a : src_a;
  assign mag_b  = sign_b ? -src_b : src_b;

  // One iteration of the multiplier or divider core
  logic [WIDTH:0]     mul_sum, div_shift, div_diff, acc_n;
  logic [WIDTH-1:0]   q_n;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  always_comb begin
    mul_sum   = q_q[0] ? (acc_q + {1'b0, b_q}) : acc_q;
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = ~div_diff[WIDTH];
    acc_n     = acc_q;
    q_n       = q_q;
    if (state_q == S_MUL) begin
      acc_n = {1'b0, mul_sum[WIDTH:1]};
      q_n   = {mul_sum[0], q_q[WIDTH-1:1]};
    end else if (state_q == S_DIV) begin
      acc_n = div_ok ? div_diff : div_shift;
      q_n   = {q_q[WIDTH-2:0], div_ok};
    end
    prod_raw = {acc_n[WIDTH-1:0], q_n};
    prod_fix = neg_lo_q ? -prod_raw : prod_raw;
    quot_fix = neg_lo_q ? -q_n : q_n;
    rem_fix  = neg_hi_q ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (accept && op_mul)      state_d = S_MUL;
        else if (accept && op_div) state_d = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush)          state_d = S_IDLE;
        else if (last_iter) state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus registered busy/done derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_MUL) || (state_d == S_DIV);
      done_q  <= (state_d == S_FIN);
    end
  end

  // Datapath: operand latch, iteration registers and HI/LO commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (accept) begin
      if (op_mthi) hi_q <= src_a;
      if (op_mtlo) lo_q <= src_a;
      if (op_mul || op_div) begin
        cnt_q <= '0;
        acc_q <= '0;
        // multiplier holds the multiplier in q and multiplicand in b;
        // divider holds the dividend in q and divisor in b
        q_q   <= op_mul ? mag_b : mag_a;
        b_q   <= op_mul ? mag_a : mag_b;
        // a zero divisor keeps the raw all-ones quotient
        neg_lo_q <= (sign_a ^ sign_b) & (op_mul | (src_b != '0));
        neg_hi_q <= op_mul ? 1'b0 : sign_a;
      end
    end else if ((state_q == S_MUL || state_q == S_DIV) && !flush) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_n;
      q_q   <= q_n;
      if (last_iter) begin
        if (state_q == S_MUL) begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end else begin
          hi_q <= rem_fix;
          lo_q <= quot_fix;
        end
      end
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stall     = busy_q & (op_valid | rd_req);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: scenario tasks checked against an arithmetic
// reference model (full-width products, / and %).
module tb_muldiv_hilo_ctrl;
  localparam int W = 32;

  logic         clk, rst_n, op_valid, rd_req, flush;
  logic [2:0]   op_code;
  logic [W-1:0] src_a, src_b, hi_out, lo_out;
  logic         busy, stall, done;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]   ref_hi, ref_lo;
  logic [2*W-1:0] exp_q[$];

  muldiv_hilo_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .rd_req(rd_req), .flush(flush),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall(stall),
    .done(done), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {hi, lo} after an op, given the current reference HI/LO
  function automatic logic [2*W-1:0] model(input logic [2:0] code,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    longint sa, sb;
    r  = {ref_hi, ref_lo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      3'd3: r = {a, ref_lo};
      3'd4: r = {ref_hi, a};
`ifdef SIGNED_MULDIV_EN
      3'd5: r = 64'(sa * sb);
      3'd6: begin
        if (b == 0)                                   r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == '1)       r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
`endif
      default: ;
    endcase
    return r;
  endfunction

  function automatic bit is_iter(input logic [2:0] code);
`ifdef SIGNED_MULDIV_EN
    return code == 3'd1 || code == 3'd2 || code == 3'd5 || code == 3'd6;
`else
    return code == 3'd1 || code == 3'd2;
`endif
  endfunction

  // Driver: present an op for one edge; returns 1ns after the accepting edge
  task automatic issue_op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = 1'b1; op_code = code; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
  endtask

  // Driver: count busy cycles until done, bounded
  task automatic wait_done(output int nb, output bit got);
    nb = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) nb++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; src_a = '0; src_b = '0;
    rd_req = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ref_hi = '0; ref_lo = '0;
  endtask

  task automatic test_reset();
    checks++;
    if (hi_out !== 0 || lo_out !== 0 || busy !== 0 || done !== 0 || stall !== 0) begin
      failures++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, want all zero",
               hi_out, lo_out, busy, done, stall);
    end
  endtask

  // Run one iterative op and check latency, pulse width and result
  task automatic run_iter(input string name, input logic [2:0] code,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    int nb; bit got; logic [2*W-1:0] e;
    e = model(code, a, b);
    exp_q.push_back(e);
    issue_op(code, a, b);
    wait_done(nb, got);
    e = exp_q.pop_front();
    checks++;
    if (!got || nb != W) begin
      failures++;
      $display("FAIL %s latency: got_done=%0d busy_cycles=%0d, want 1 and %0d", name, got, nb, W);
    end
    checks++;
    if ({hi_out, lo_out} !== e) begin
      failures++;
      $display("FAIL %s result: hi=%h lo=%h, want hi=%h lo=%h", name, hi_out, lo_out, e[2*W-1:W], e[W-1:0]);
    end
    ref_hi = e[2*W-1:W]; ref_lo = e[W-1:0];
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width: done=%b one cycle after pulse, want 0", name, done);
    end
  endtask

  task automatic test_multu_max();
    run_iter("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001) begin
      failures++;
      $display("FAIL multu_max_const: hi=%h lo=%h, want fffffffe 00000001", hi_out, lo_out);
    end
  endtask

  task automatic test_divu();
    run_iter("divu_100_7", 3'd2, 32'd100, 32'd7);
    checks++;
    if (hi_out !== 32'd2 || lo_out !== 32'd14) begin
      failures++;
      $display("FAIL divu_100_7_const: hi=%0d lo=%0d, want 2 14", hi_out, lo_out);
    end
    run_iter("divu_by_zero", 3'd2, 32'd5, 32'd0);
    checks++;
    if (hi_out !== 32'd5 || lo_out !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL divu_by_zero_const: hi=%h lo=%h, want 00000005 ffffffff", hi_out, lo_out);
    end
  endtask

  task automatic test_mt();
    logic [W-1:0] old_lo;
    old_lo = lo_out;
    issue_op(3'd3, 32'h1234_5678, 32'd0);
    checks++;
    if (hi_out !== 32'h1234_5678 || lo_out !== old_lo || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b, want 12345678 %h 0", hi_out, lo_out, busy, old_lo);
    end
    issue_op(3'd4, 32'h9ABC_DEF0, 32'd0);
    checks++;
    if (hi_out !== 32'h1234_5678 || lo_out !== 32'h9ABC_DEF0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b, want 12345678 9abcdef0 0", hi_out, lo_out, busy);
    end
    ref_hi = 32'h1234_5678; ref_lo = 32'h9ABC_DEF0;
  endtask

  task automatic test_random();
    logic [2:0] code; logic [W-1:0] a, b; logic [2*W-1:0] e;
    for (int i = 0; i < 24; i++) begin
      code = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      if (is_iter(code)) begin
        run_iter("random_iter", code, a, b);
      end else begin
        e = model(code, a, b);
        exp_q.push_back(e);
        issue_op(code, a, b);
        e = exp_q.pop_front();
        checks++;
        if ({hi_out, lo_out} !== e || busy !== 1'b0) begin
          failures++;
          $display("FAIL random_code%0d: hi=%h lo=%h busy=%b, want %h %h 0",
                   code, hi_out, lo_out, busy, e[2*W-1:W], e[W-1:0]);
        end
        ref_hi = e[2*W-1:W]; ref_lo = e[W-1:0];
      end
    end
  endtask

  task automatic test_back_to_back();
    int nb; bit got; logic [2*W-1:0] e1, e2;
    logic [W-1:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = W'($urandom_range(1, 1000));
    e1 = model(3'd1, a1, b1);
    exp_q.push_back(e1);
    issue_op(3'd1, a1, b1);
    op_valid = 1'b1; op_code = 3'd2; src_a = a2; src_b = b2; rd_req = 1'b1;
    nb = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (done) begin got = 1'b1; break; end
      if (busy) begin
        nb++;
        checks++;
        if (stall !== 1'b1) begin
          failures++;
          $display("FAIL b2b_stall: stall=%b on busy cycle %0d, want 1", stall, nb);
        end
      end
      @(posedge clk); #1;
    end
    e1 = exp_q.pop_front();
    checks++;
    if (!got || nb != W || stall !== 1'b0 || {hi_out, lo_out} !== e1) begin
      failures++;
      $display("FAIL b2b_first: got=%0d busy=%0d stall=%b hi=%h lo=%h, want 1 %0d 0 %h %h",
               got, nb, stall, hi_out, lo_out, W, e1[2*W-1:W], e1[W-1:0]);
    end
    ref_hi = e1[2*W-1:W]; ref_lo = e1[W-1:0];
    e2 = model(3'd2, a2, b2);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0; rd_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || {hi_out, lo_out} !== e1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b hi=%h lo=%h, want 1 %h %h",
               busy, hi_out, lo_out, e1[2*W-1:W], e1[W-1:0]);
    end
    wait_done(nb, got);
    checks++;
    if (!got || nb != W || {hi_out, lo_out} !== e2) begin
      failures++;
      $display("FAIL b2b_second: got=%0d busy=%0d hi=%h lo=%h, want 1 %0d %h %h",
               got, nb, hi_out, lo_out, W, e2[2*W-1:W], e2[W-1:0]);
    end
    ref_hi = e2[2*W-1:W]; ref_lo = e2[W-1:0];
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int nb, dones; bit got;
    issue_op(3'd3, 32'hA5A5_A5A5, 32'd0);
    issue_op(3'd4, 32'hA5A5_A5A5, 32'd0);
    issue_op(3'd2, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi_out !== 32'hA5A5_A5A5 || lo_out !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL flush_busy: busy=%b done=%b hi=%h lo=%h, want 0 0 a5a5a5a5 a5a5a5a5",
               busy, done, hi_out, lo_out);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL flush_quiet: %0d busy/done cycles after flush, want 0", dones);
    end
    // flush together with op_valid: op dropped
    op_valid = 1'b1; op_code = 3'd3; src_a = 32'h1111_1111; flush = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0; flush = 1'b0;
    checks++;
    if (hi_out !== 32'hA5A5_A5A5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_same_cycle: hi=%h busy=%b, want a5a5a5a5 0", hi_out, busy);
    end
    // flush during the done cycle: result already committed
    issue_op(3'd1, 32'd3, 32'd5);
    wait_done(nb, got);
    flush = 1'b1;
    checks++;
    if (!got || done !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd15) begin
      failures++;
      $display("FAIL flush_fin: got=%0d done=%b hi=%h lo=%h, want 1 1 0 15", got, done, hi_out, lo_out);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lo_out !== 32'd15) begin
      failures++;
      $display("FAIL flush_fin_after: done=%b busy=%b lo=%h, want 0 0 15", done, busy, lo_out);
    end
    ref_hi = 32'd0; ref_lo = 32'd15;
    // async reset mid-operation
    issue_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hi_out !== 0 || lo_out !== 0 || busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL reset_mid_op: hi=%h lo=%h busy=%b done=%b, want all zero", hi_out, lo_out, busy, done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    ref_hi = '0; ref_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hi_out !== 0 || lo_out !== 0 || busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL reset_after: hi=%h lo=%h busy=%b done=%b, want all zero", hi_out, lo_out, busy, done);
    end
  endtask

`ifdef SIGNED_MULDIV_EN
  task automatic test_signed();
    run_iter("div_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_m7_2_const: hi=%h lo=%h, want ffffffff fffffffd", hi_out, lo_out);
    end
    run_iter("mult_m3_4", 3'd5, 32'hFFFF_FFFD, 32'd4);
    checks++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFF4) begin
      failures++;
      $display("FAIL mult_m3_4_const: hi=%h lo=%h, want ffffffff fffffff4", hi_out, lo_out);
    end
    run_iter("div_minneg", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_iter("div_signed_zero", 3'd6, 32'hFFFF_FF00, 32'd0);
    run_iter("mult_neg_neg", 3'd5, 32'h8000_0000, 32'h8000_0000);
  endtask
`else
  task automatic test_signed();
    logic [W-1:0] h, l;
    issue_op(3'd3, 32'h0BAD_F00D, 32'd0);
    issue_op(3'd4, 32'h600D_CAFE, 32'd0);
    h = 32'h0BAD_F00D; l = 32'h600D_CAFE;
    ref_hi = h; ref_lo = l;
    for (int c = 5; c <= 7; c++) begin
      issue_op(3'(c), $urandom, $urandom_range(1, 50));
      repeat (3) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi_out !== h || lo_out !== l) begin
          failures++;
          $display("FAIL nop_code%0d: busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
                   c, busy, done, hi_out, lo_out, h, l);
        end
        @(posedge clk); #1;
      end
    end
  endtask
`endif

  initial begin
    do_reset();
    #1;
    test_reset();
    test_multu_max();
    test_divu();
    test_mt();
    test_back_to_back();
    test_random();
    test_flush();
    test_signed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
